// File: rtl/voice_allocator.sv
// Voice allocator: queues key presses, assigns each to one of a fixed pool of voices,
// steals the oldest voice when none is free, and tracks each voice through hold and release.
module voice_allocator #(
    parameter int NUM_KEYS       = 24,
    parameter int NUM_VOICES     = 4,
    parameter int KEY_W          = 5,
    parameter int RELEASE_CYCLES = 4800,
    parameter int AGE_W          = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_KEYS-1:0]         gate_in,
    input  logic [NUM_KEYS-1:0]         trigger_in,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key_out,
    output logic [NUM_VOICES-1:0]       voice_gate_out,
    output logic [NUM_VOICES-1:0]       voice_active_out,
    output logic [NUM_VOICES-1:0]       voice_trigger_out,
    output logic                        steal_out,
    output logic                        pending_out
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        HELD    = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

    voice_state_t       state_q [NUM_VOICES];
    voice_state_t       state_d [NUM_VOICES];
    logic [KEY_W-1:0]   key_q   [NUM_VOICES];
    logic [KEY_W-1:0]   key_d   [NUM_VOICES];
    logic [AGE_W-1:0]   age_q   [NUM_VOICES];
    logic [AGE_W-1:0]   age_d   [NUM_VOICES];
    logic [CNT_W-1:0]   rel_q   [NUM_VOICES];
    logic [CNT_W-1:0]   rel_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] trig_d;

    logic [NUM_KEYS-1:0] pending_q;
    logic [NUM_KEYS-1:0] pending_d;
    logic [NUM_KEYS-1:0] svc_onehot;
    logic                svc_valid;
    logic [KEY_W-1:0]    svc_key;

    logic                hit_found, free_found, rel_found, held_found;
    logic [VIDX_W-1:0]   hit_idx, free_idx, rel_idx, held_idx, alloc_idx;
    logic [AGE_W-1:0]    rel_age, held_age;
    logic                steal_d;

    // Lowest-index pending key is serviced; a fresh trigger on that key re-queues it.
    assign svc_onehot = pending_q & (~pending_q + 1'b1);
    assign pending_d  = ((pending_q & ~svc_onehot) | trigger_in) & gate_in;

    // NOTE: every variable written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        svc_valid = 1'b0;
        svc_key   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                svc_valid = 1'b1;
                svc_key   = KEY_W'(i);
            end
        end
    end

    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        rel_found  = 1'b0;
        held_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        rel_idx    = '0;
        held_idx   = '0;
        rel_age    = '0;
        held_age   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (state_q[v] != FREE && key_q[v] == svc_key && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = VIDX_W'(v);
            end
            if (state_q[v] == FREE && !free_found) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(v);
            end
            // Strict compare keeps the lowest index on equal ages.
            if (state_q[v] == RELEASE && (!rel_found || age_q[v] > rel_age)) begin
                rel_found = 1'b1;
                rel_idx   = VIDX_W'(v);
                rel_age   = age_q[v];
            end
            if (state_q[v] == HELD && (!held_found || age_q[v] > held_age)) begin
                held_found = 1'b1;
                held_idx   = VIDX_W'(v);
                held_age   = age_q[v];
            end
        end

        if (hit_found)       alloc_idx = hit_idx;
        else if (free_found) alloc_idx = free_idx;
        else if (rel_found)  alloc_idx = rel_idx;
        else                 alloc_idx = held_idx;

        steal_d = svc_valid & ~hit_found & ~free_found & ~rel_found & held_found;
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_d[v] = state_q[v];
            key_d[v]   = key_q[v];
            age_d[v]   = age_q[v];
            rel_d[v]   = rel_q[v];
            trig_d[v]  = 1'b0;

            case (state_q[v])
                FREE: begin
                    age_d[v] = '0;
                end
                HELD: begin
                    age_d[v] = (age_q[v] == AGE_MAX) ? AGE_MAX : age_q[v] + 1'b1;
                    if (!gate_in[key_q[v]]) begin
                        state_d[v] = RELEASE;
                        rel_d[v]   = REL_LOAD;
                    end
                end
                RELEASE: begin
                    if (rel_q[v] == '0) begin
                        state_d[v] = FREE;
                        age_d[v]   = '0;
                    end else begin
                        rel_d[v] = rel_q[v] - 1'b1;
                        age_d[v] = (age_q[v] == AGE_MAX) ? AGE_MAX : age_q[v] + 1'b1;
                    end
                end
                default: begin
                    state_d[v] = FREE;
                    age_d[v]   = '0;
                end
            endcase

            // Allocation overrides any release/free transition on the same voice.
            if (svc_valid && alloc_idx == VIDX_W'(v)) begin
                state_d[v] = HELD;
                key_d[v]   = svc_key;
                age_d[v]   = '0;
                rel_d[v]   = '0;
                trig_d[v]  = 1'b1;
            end
        end
    end

    // NOTE: the per-voice register arrays are small state, not storage memories,
    // so they are cleared by the reset like every other flop.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= FREE;
                key_q[v]   <= '0;
                age_q[v]   <= '0;
                rel_q[v]   <= '0;
            end
            pending_q         <= '0;
            voice_gate_out    <= '0;
            voice_active_out  <= '0;
            voice_trigger_out <= '0;
            steal_out         <= 1'b0;
            pending_out       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v]          <= state_d[v];
                key_q[v]            <= key_d[v];
                age_q[v]            <= age_d[v];
                rel_q[v]            <= rel_d[v];
                voice_gate_out[v]   <= (state_d[v] == HELD);
                voice_active_out[v] <= (state_d[v] != FREE);
            end
            pending_q         <= pending_d;
            voice_trigger_out <= trig_d;
            steal_out         <= steal_d;
            pending_out       <= |pending_d;
        end
    end

    always_comb begin
        voice_key_out = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_key_out[v*KEY_W +: KEY_W] = key_q[v];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation latency, queueing, stealing,
// release timing, retrigger and asynchronous reset, with RELEASE_CYCLES = 8.
module tb_voice_allocator;

    localparam int NUM_KEYS   = 24;
    localparam int NUM_VOICES = 4;
    localparam int KEY_W      = 5;

    logic                        clk_in = 1'b0;
    logic                        rst_in;
    logic [NUM_KEYS-1:0]         gate_in;
    logic [NUM_KEYS-1:0]         trigger_in;
    logic [NUM_VOICES*KEY_W-1:0] voice_key_out;
    logic [NUM_VOICES-1:0]       voice_gate_out;
    logic [NUM_VOICES-1:0]       voice_active_out;
    logic [NUM_VOICES-1:0]       voice_trigger_out;
    logic                        steal_out;
    logic                        pending_out;

    int total = 0;
    int bad   = 0;

    voice_allocator #(
        .NUM_KEYS(NUM_KEYS),
        .NUM_VOICES(NUM_VOICES),
        .KEY_W(KEY_W),
        .RELEASE_CYCLES(8),
        .AGE_W(16)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .gate_in(gate_in),
        .trigger_in(trigger_in),
        .voice_key_out(voice_key_out),
        .voice_gate_out(voice_gate_out),
        .voice_active_out(voice_active_out),
        .voice_trigger_out(voice_trigger_out),
        .steal_out(steal_out),
        .pending_out(pending_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [19:0] kb(input int k0, input int k1, input int k2, input int k3);
        return {5'(k3), 5'(k2), 5'(k1), 5'(k0)};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        gate_in    = '0;
        trigger_in = '0;
        rst_in     = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key"},    32'(voice_key_out),     32'h0);
        check({tag, "_gate"},   32'(voice_gate_out),    32'h0);
        check({tag, "_active"}, 32'(voice_active_out),  32'h0);
        check({tag, "_trig"},   32'(voice_trigger_out), 32'h0);
        check({tag, "_steal"},  32'(steal_out),         32'h0);
        check({tag, "_pend"},   32'(pending_out),       32'h0);
    endtask

    initial begin
        rst_in     = 1'b1;
        gate_in    = '0;
        trigger_in = '0;
        step();
        step();
        check_all_zero("reset");
        rst_in = 1'b0;

        // Single key: voice 0 takes key 3 two cycles after the trigger.
        gate_in    = 24'h000008;
        trigger_in = 24'h000008;
        step();
        trigger_in = '0;
        check("t1_pend_c1", 32'(pending_out), 32'h1);
        check("t1_trig_c1", 32'(voice_trigger_out), 32'h0);
        step();
        check("t1_key_c2",  32'(voice_key_out), 32'(kb(3, 0, 0, 0)));
        check("t1_gate_c2", 32'(voice_gate_out), 32'h1);
        check("t1_trig_c2", 32'(voice_trigger_out), 32'h1);
        check("t1_act_c2",  32'(voice_active_out), 32'h1);
        step();
        check("t1_trig_c3", 32'(voice_trigger_out), 32'h0);
        check("t1_gate_c3", 32'(voice_gate_out), 32'h1);

        // Three simultaneous keys are serviced one per cycle, lowest index first.
        do_reset();
        gate_in    = 24'h000222;
        trigger_in = 24'h000222;
        step();
        trigger_in = '0;
        check("t2_pend_c1", 32'(pending_out), 32'h1);
        step();
        check("t2_trig_c2", 32'(voice_trigger_out), 32'h1);
        check("t2_key_c2",  32'(voice_key_out), 32'(kb(1, 0, 0, 0)));
        check("t2_pend_c2", 32'(pending_out), 32'h1);
        step();
        check("t2_trig_c3", 32'(voice_trigger_out), 32'h2);
        check("t2_key_c3",  32'(voice_key_out), 32'(kb(1, 5, 0, 0)));
        check("t2_pend_c3", 32'(pending_out), 32'h1);
        step();
        check("t2_trig_c4", 32'(voice_trigger_out), 32'h4);
        check("t2_key_c4",  32'(voice_key_out), 32'(kb(1, 5, 9, 0)));
        check("t2_pend_c4", 32'(pending_out), 32'h0);
        check("t2_gate_c4", 32'(voice_gate_out), 32'h7);
        step();
        check("t2_trig_c5", 32'(voice_trigger_out), 32'h0);

        // Pool full of held keys 0-3: key 10 steals the oldest voice (voice 0).
        do_reset();
        gate_in    = 24'h00000F;
        trigger_in = 24'h00000F;
        step();
        trigger_in = '0;
        step();
        step();
        step();
        step();
        check("t3_gate_full", 32'(voice_gate_out), 32'hF);
        check("t3_key_full",  32'(voice_key_out), 32'(kb(0, 1, 2, 3)));
        check("t3_steal_pre", 32'(steal_out), 32'h0);
        gate_in    = 24'h00040F;
        trigger_in = 24'h000400;
        step();
        trigger_in = '0;
        step();
        check("t3_steal",      32'(steal_out), 32'h1);
        check("t3_trig",       32'(voice_trigger_out), 32'h1);
        check("t3_key_stolen", 32'(voice_key_out), 32'(kb(10, 1, 2, 3)));
        check("t3_gate_stay",  32'(voice_gate_out), 32'hF);
        step();
        check("t3_steal_once", 32'(steal_out), 32'h0);

        // Retrigger of a key already held on voice 1: same voice, no steal.
        trigger_in = 24'h000002;
        step();
        trigger_in = '0;
        step();
        check("rt_trig",  32'(voice_trigger_out), 32'h2);
        check("rt_steal", 32'(steal_out), 32'h0);
        check("rt_key",   32'(voice_key_out), 32'(kb(10, 1, 2, 3)));

        // Release key 2: voice 2 stays active for exactly 8 cycles.
        gate_in = 24'h00040B;
        step();
        check("t4_gate_rel", 32'(voice_gate_out), 32'hB);
        check("t4_act_c1",   32'(voice_active_out), 32'hF);
        for (int i = 2; i <= 8; i++) begin
            step();
            check("t4_act_hold", 32'(voice_active_out), 32'hF);
        end
        step();
        check("t4_act_free", 32'(voice_active_out), 32'hB);
        check("t4_gate_free", 32'(voice_gate_out), 32'hB);
        check("t4_key_kept", 32'(voice_key_out), 32'(kb(10, 1, 2, 3)));

        // Key 2 again takes the free voice 2, then is released and retriggered mid-release.
        gate_in    = 24'h00040F;
        trigger_in = 24'h000004;
        step();
        trigger_in = '0;
        step();
        check("t4_realloc", 32'(voice_trigger_out), 32'h4);
        gate_in = 24'h00040B;
        step();
        step();
        step();
        check("t4_in_rel", 32'(voice_gate_out), 32'hB);
        gate_in    = 24'h00040F;
        trigger_in = 24'h000004;
        step();
        trigger_in = '0;
        step();
        check("t4_retrig",       32'(voice_trigger_out), 32'h4);
        check("t4_retrig_steal", 32'(steal_out), 32'h0);
        check("t4_retrig_gate",  32'(voice_gate_out), 32'hF);
        check("t4_retrig_key",   32'(voice_key_out), 32'(kb(10, 1, 2, 3)));

        // One voice in release, three held: new key 12 takes the releasing voice.
        gate_in = 24'h00040B;
        step();
        step();
        check("t5_gate_pre", 32'(voice_gate_out), 32'hB);
        gate_in    = 24'h00140B;
        trigger_in = 24'h001000;
        step();
        trigger_in = '0;
        step();
        check("t5_trig",  32'(voice_trigger_out), 32'h4);
        check("t5_steal", 32'(steal_out), 32'h0);
        check("t5_key",   32'(voice_key_out), 32'(kb(10, 1, 12, 3)));
        check("t5_gate",  32'(voice_gate_out), 32'hF);

        // Asynchronous reset in the middle of the three-key burst.
        do_reset();
        gate_in    = 24'h000222;
        trigger_in = 24'h000222;
        step();
        trigger_in = '0;
        step();
        check("t6_pre_trig", 32'(voice_trigger_out), 32'h1);
        #2;
        rst_in = 1'b1;
        #1;
        check_all_zero("t6_async");
        step();
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_trig", 32'(voice_trigger_out), 32'h0);
            check("t6_no_pend", 32'(pending_out), 32'h0);
            check("t6_no_act",  32'(voice_active_out), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
